// File: rtl/wide_word_serializer_pkg.sv
// cnn_stream_pkg: shared sizing helpers for the wide-word serializer slice.
//   calc_beats(in_w, out_w) : number of narrow beats per wide word
//   calc_bw(beats)          : beat-index width, never less than 1 bit
//   beat_idx_t              : beat index for the default 4096/512 geometry;
//                             modules with other geometries declare their own
//                             index type from calc_bw().
package cnn_stream_pkg;

    localparam int unsigned DEF_IN_WIDTH  = 4096;
    localparam int unsigned DEF_OUT_WIDTH = 512;

    function automatic int unsigned calc_beats(input int unsigned in_w,
                                               input int unsigned out_w);
        return in_w / out_w;
    endfunction

    function automatic int unsigned calc_bw(input int unsigned beats);
        return (beats <= 1) ? 1 : $clog2(beats);
    endfunction

    typedef logic [calc_bw(calc_beats(DEF_IN_WIDTH, DEF_OUT_WIDTH))-1:0] beat_idx_t;

endpackage

// File: rtl/wide_word_serializer_if.sv
// Bus bundle for wide_word_serializer.
//   in_data/in_valid  : wide word pulse from the CDC stage (no backpressure)
//   out_*             : narrow beat stream, valid/ready handshake
//   busy/overflow     : status
// slave  = serializer side, master = producer/consumer side.
interface wide_word_serializer_if
    import cnn_stream_pkg::*;
#(
    parameter int unsigned IN_WIDTH  = 4096,
    parameter int unsigned OUT_WIDTH = 512
);

    localparam int unsigned BW = calc_bw(calc_beats(IN_WIDTH, OUT_WIDTH));

    logic [IN_WIDTH-1:0]  in_data;
    logic                 in_valid;
    logic [OUT_WIDTH-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [BW-1:0]        out_beat;
    logic                 out_last;
    logic                 busy;
    logic                 overflow;

    modport slave (
        input  in_data, in_valid, out_ready,
        output out_data, out_valid, out_beat, out_last, busy, overflow
    );

    modport master (
        output in_data, in_valid, out_ready,
        input  out_data, out_valid, out_beat, out_last, busy, overflow
    );

endinterface

// File: rtl/wide_word_serializer_fifo.sv
// wide_word_fifo: DEPTH x WIDTH word buffer with same-cycle push+pop.
//   clk, reset : clock, synchronous active-high reset (pointers/count only)
//   push       : write push_data at the tail (caller guarantees room or pop)
//   pop        : retire the head word (caller guarantees non-empty)
//   head       : current head word (combinational read of registered storage)
//   full/empty : occupancy flags
module wide_word_fifo #(
    parameter int unsigned WIDTH = 4096,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    logic [WIDTH-1:0] mem [DEPTH];
    ptr_t             wr_ptr;
    ptr_t             rd_ptr;
    cnt_t             count;

    // Explicit wrap keeps DEPTH==1 (1-bit pointer, one slot) correct.
    function automatic ptr_t next_ptr(input ptr_t p);
        return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    // Storage is not reset. When full, a push with pop overwrites the slot
    // being retired; its last beat has already been read this cycle.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + cnt_t'(1);
                2'b01:   count <= count - cnt_t'(1);
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == cnt_t'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/wide_word_serializer.sv
// wide_word_serializer: buffers wide words from the CDC stage and streams them
// out LSB-first as OUT_WIDTH beats under valid/ready.
//   clk   : destination clock, all logic on posedge
//   reset : synchronous active-high reset
//   bus   : wide_word_serializer_if.slave (in_data/in_valid, out_data/out_valid/
//           out_ready/out_beat/out_last, busy, sticky overflow)
module wide_word_serializer
    import cnn_stream_pkg::*;
#(
    parameter int unsigned IN_WIDTH  = 4096,
    parameter int unsigned OUT_WIDTH = 512,
    parameter int unsigned DEPTH     = 2
) (
    input logic                  clk,
    input logic                  reset,
    wide_word_serializer_if.slave bus
);

    localparam int unsigned BEATS = calc_beats(IN_WIDTH, OUT_WIDTH);
    localparam int unsigned BW    = calc_bw(BEATS);

    typedef logic [BW-1:0] beat_t;

    generate
        if ((IN_WIDTH % OUT_WIDTH) != 0) begin : g_bad_width
            $error("wide_word_serializer: IN_WIDTH must be a multiple of OUT_WIDTH");
        end
        if ((DEPTH == 0) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("wide_word_serializer: DEPTH must be a power of two");
        end
    endgenerate

    logic [IN_WIDTH-1:0]  head;
    logic [OUT_WIDTH-1:0] out_mux;
    logic                 full;
    logic                 empty;
    logic                 xfer;
    logic                 last;
    logic                 pop;
    logic                 push;
    beat_t                beat_q;
    logic                 overflow_q;

    assign xfer = !empty && bus.out_ready;
    assign last = (beat_q == beat_t'(BEATS - 1));
    assign pop  = xfer && last;
    // A pop frees the head slot in the same cycle, so a full buffer still
    // accepts a word arriving alongside the last beat.
    assign push = bus.in_valid && (!full || pop);

    wide_word_fifo #(
        .WIDTH (IN_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (bus.in_data),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    generate
        if (BEATS == 1) begin : g_single_beat
            assign beat_q = '0;
        end else begin : g_beat_cnt
            always_ff @(posedge clk) begin
                if (reset) begin
                    beat_q <= '0;
                end else if (xfer) begin
                    beat_q <= last ? '0 : beat_q + beat_t'(1);
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else if (bus.in_valid && full && !pop) begin
            overflow_q <= 1'b1;
        end
    end

    always_comb begin
        out_mux = '0;
        for (int unsigned k = 0; k < BEATS; k++) begin
            if (beat_q == beat_t'(k)) begin
                out_mux = head[k*OUT_WIDTH +: OUT_WIDTH];
            end
        end
    end

    assign bus.out_data  = out_mux;
    assign bus.out_valid = !empty;
    assign bus.busy      = !empty;
    assign bus.out_beat  = beat_q;
    assign bus.out_last  = !empty && last;
    assign bus.overflow  = overflow_q;

endmodule
